// File: rtl/risc16_pkg.sv
// Shared widths and inter-stage bundles for the 16-bit RISC core.
// Imported by the operand fetch stage and its scoreboard.
package risc16_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int OP_W     = 4;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              rd_en;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } dec_instr_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] rd;
        logic              rd_en;
    } of_ex_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for writes in flight, with combinational lookups.
// A set on the same address as a clear in the same cycle leaves the bit set.
module reg_scoreboard
    import risc16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              fclr_en,
    input  logic [ADDR_W-1:0] fclr_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              busy_rd
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (fclr_en)
            busy_nxt[fclr_addr] = 1'b0;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (set_en)
            busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];
    assign busy_rd  = busy[rd];

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch stage with scoreboard hazard stalls.
// Define OPFETCH_FWD_EN to forward same-cycle writebacks into the operands.
module operand_fetch
    import risc16_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [OP_W-1:0]   IN_OP,
    input  logic [ADDR_W-1:0] IN_RS1,
    input  logic [ADDR_W-1:0] IN_RS2,
    input  logic [ADDR_W-1:0] IN_RD,
    input  logic              IN_RD_EN,
    input  logic              IN_USE_IMM,
    input  logic [DATA_W-1:0] IN_IMM,
    output logic [ADDR_W-1:0] RADDR1,
    output logic [ADDR_W-1:0] RADDR2,
    input  logic [DATA_W-1:0] RA_DATA,
    input  logic [DATA_W-1:0] RB_DATA,
    input  logic              WB_WE,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [OP_W-1:0]   OUT_OP,
    output logic [DATA_W-1:0] OUT_A,
    output logic [DATA_W-1:0] OUT_B,
    output logic [ADDR_W-1:0] OUT_RD,
    output logic              OUT_RD_EN
);

`ifdef OPFETCH_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    dec_instr_t in_i;
    of_ex_t     out_q;
    logic       out_valid_q;

    logic busy_rs1, busy_rs2, busy_rd;
    logic wb_hit1, wb_hit2, wb_hit_rd;
    logic src1_ok, src2_ok, waw;
    logic hazard, accept;
    logic [DATA_W-1:0] a_val, b_val;

    assign in_i.op      = IN_OP;
    assign in_i.rs1     = IN_RS1;
    assign in_i.rs2     = IN_RS2;
    assign in_i.rd      = IN_RD;
    assign in_i.rd_en   = IN_RD_EN;
    assign in_i.use_imm = IN_USE_IMM;
    assign in_i.imm     = IN_IMM;

    assign RADDR1 = in_i.rs1;
    assign RADDR2 = in_i.rs2;

    reg_scoreboard u_sb (
        .clk       (CLK),
        .rst_n     (RST_N),
        .set_en    (accept && in_i.rd_en),
        .set_addr  (in_i.rd),
        .clr_en    (WB_WE),
        .clr_addr  (WB_ADDR),
        .fclr_en   (FLUSH && out_valid_q && out_q.rd_en),
        .fclr_addr (out_q.rd),
        .rs1       (in_i.rs1),
        .rs2       (in_i.rs2),
        .rd        (in_i.rd),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd)
    );

    assign wb_hit1   = WB_WE && (WB_ADDR == in_i.rs1);
    assign wb_hit2   = WB_WE && (WB_ADDR == in_i.rs2);
    assign wb_hit_rd = WB_WE && (WB_ADDR == in_i.rd);

    // Without forwarding a same-cycle write is not yet readable: wait a cycle.
    assign src1_ok = FWD_EN ? (!busy_rs1 || wb_hit1)
                            : (!busy_rs1 && !wb_hit1);
    assign src2_ok = FWD_EN ? (!busy_rs2 || wb_hit2)
                            : (!busy_rs2 && !wb_hit2);
    assign waw     = in_i.rd_en && busy_rd && !wb_hit_rd;

    assign hazard = !src1_ok
                 || (!in_i.use_imm && !src2_ok)
                 || waw;

    assign IN_READY = (!out_valid_q || OUT_READY) && !hazard && !FLUSH;
    assign accept   = IN_VALID && IN_READY;

    assign a_val = (FWD_EN && wb_hit1) ? WB_DATA : RA_DATA;
    assign b_val = in_i.use_imm        ? in_i.imm
                 : (FWD_EN && wb_hit2) ? WB_DATA
                 :                       RB_DATA;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q.op    <= in_i.op;
            out_q.a     <= a_val;
            out_q.b     <= b_val;
            out_q.rd    <= in_i.rd;
            out_q.rd_en <= in_i.rd_en;
        end else if (FLUSH || OUT_READY) begin
            out_valid_q <= 1'b0;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_OP    = out_q.op;
    assign OUT_A     = out_q.a;
    assign OUT_B     = out_q.b;
    assign OUT_RD    = out_q.rd;
    assign OUT_RD_EN = out_q.rd_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run
// against a register-file / scoreboard model kept in the bench.
module tb_operand_fetch;
    import risc16_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              IN_VALID, IN_READY;
    logic [OP_W-1:0]   IN_OP;
    logic [ADDR_W-1:0] IN_RS1, IN_RS2, IN_RD;
    logic              IN_RD_EN, IN_USE_IMM;
    logic [DATA_W-1:0] IN_IMM;
    logic [ADDR_W-1:0] RADDR1, RADDR2;
    logic [DATA_W-1:0] RA_DATA, RB_DATA;
    logic              WB_WE;
    logic [ADDR_W-1:0] WB_ADDR;
    logic [DATA_W-1:0] WB_DATA;
    logic              FLUSH;
    logic              OUT_VALID, OUT_READY;
    logic [OP_W-1:0]   OUT_OP;
    logic [DATA_W-1:0] OUT_A, OUT_B;
    logic [ADDR_W-1:0] OUT_RD;
    logic              OUT_RD_EN;

    always #5 CLK = ~CLK;

    operand_fetch dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OP(IN_OP), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2),
        .IN_RD(IN_RD), .IN_RD_EN(IN_RD_EN),
        .IN_USE_IMM(IN_USE_IMM), .IN_IMM(IN_IMM),
        .RADDR1(RADDR1), .RADDR2(RADDR2),
        .RA_DATA(RA_DATA), .RB_DATA(RB_DATA),
        .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_OP(OUT_OP), .OUT_A(OUT_A), .OUT_B(OUT_B),
        .OUT_RD(OUT_RD), .OUT_RD_EN(OUT_RD_EN)
    );

    // Register file model; reads are combinational like the real one.
    logic [DATA_W-1:0] rf [NUM_REGS];
    assign RA_DATA = rf[RADDR1];
    assign RB_DATA = rf[RADDR2];

    // Architectural model of in-flight writers and the output register.
    logic [NUM_REGS-1:0] m_busy;
    logic                m_valid;
    logic [OP_W-1:0]     m_op;
    logic [DATA_W-1:0]   m_a, m_b;
    logic [ADDR_W-1:0]   m_rd;
    logic                m_rd_en;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic wb_hits(input logic [ADDR_W-1:0] s);
        return WB_WE && (WB_ADDR == s);
    endfunction

    // A source is usable when its newest value can be obtained this cycle.
    function automatic logic src_known(input logic [ADDR_W-1:0] s);
`ifdef OPFETCH_FWD_EN
        return !m_busy[s] || wb_hits(s);
`else
        return !m_busy[s] && !wb_hits(s);
`endif
    endfunction

    function automatic logic [DATA_W-1:0] src_value(input logic [ADDR_W-1:0] s);
        return wb_hits(s) ? WB_DATA : rf[s];
    endfunction

    function automatic logic model_ready();
        logic room, srcs, waw;
        room = !m_valid || OUT_READY;
        srcs = src_known(IN_RS1) && (IN_USE_IMM || src_known(IN_RS2));
        waw  = IN_RD_EN && m_busy[IN_RD] && !wb_hits(IN_RD);
        return room && srcs && !waw && !FLUSH;
    endfunction

    task automatic idle();
        IN_VALID = 0; IN_OP = '0; IN_RS1 = '0; IN_RS2 = '0;
        IN_RD = '0; IN_RD_EN = 0; IN_USE_IMM = 0; IN_IMM = '0;
        WB_WE = 0; WB_ADDR = '0; WB_DATA = '0;
        FLUSH = 0; OUT_READY = 1;
    endtask

    task automatic present(input logic [OP_W-1:0] op,
                           input logic [ADDR_W-1:0] rs1,
                           input logic [ADDR_W-1:0] rs2,
                           input logic [ADDR_W-1:0] rd,
                           input logic rd_en);
        IN_VALID = 1; IN_OP = op; IN_RS1 = rs1; IN_RS2 = rs2;
        IN_RD = rd; IN_RD_EN = rd_en; IN_USE_IMM = 0; IN_IMM = '0;
    endtask

    // Advance one clock, stepping the model with the inputs now applied.
    task automatic tick();
        logic                acc;
        logic [NUM_REGS-1:0] nb;
        logic                nv;
        nb  = m_busy;
        nv  = m_valid;
        acc = IN_VALID && model_ready();
        if (FLUSH && m_valid && m_rd_en)
            nb[m_rd] = 1'b0;
        if (WB_WE)
            nb[WB_ADDR] = 1'b0;
        if (acc && IN_RD_EN)
            nb[IN_RD] = 1'b1;
        if (acc) begin
            nv      = 1'b1;
            m_op    = IN_OP;
            m_a     = src_value(IN_RS1);
            m_b     = IN_USE_IMM ? IN_IMM : src_value(IN_RS2);
            m_rd    = IN_RD;
            m_rd_en = IN_RD_EN;
        end else if (FLUSH || OUT_READY) begin
            nv = 1'b0;
        end
        @(posedge CLK);
        #1;
        m_busy  = nb;
        m_valid = nv;
        if (WB_WE)
            rf[WB_ADDR] = WB_DATA;
    endtask

    task automatic model_clear();
        m_busy = '0; m_valid = 0; m_op = '0; m_a = '0;
        m_b = '0; m_rd = '0; m_rd_en = 0;
    endtask

    task automatic do_reset();
        RST_N = 0;
        idle();
        model_clear();
        for (int i = 0; i < NUM_REGS; i++)
            rf[i] = DATA_W'($urandom);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if ({OUT_VALID, OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_RD_EN} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h rd=%h en=%b, want all zero",
                     OUT_VALID, OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_RD_EN);
        end
        n_vec++;
        if (IN_READY !== 1'b1 || dut.u_sb.busy !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ready: got ready=%b busy=%h, want 1 and 00",
                     IN_READY, dut.u_sb.busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        rf[2] = 16'h0625;
        rf[3] = 16'h00CB;
        present(4'h1, 3'd2, 3'd3, 3'd4, 1'b1);
        #1;
        n_vec++;
        if (RADDR1 !== 3'd2 || RADDR2 !== 3'd3 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL basic_raddr: got r1=%0d r2=%0d ready=%b, want 2 3 1",
                     RADDR1, RADDR2, IN_READY);
        end
        tick();
        idle();
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 16'h0625 || OUT_B !== 16'h00CB
            || OUT_RD !== 3'd4 || OUT_RD_EN !== 1'b1 || OUT_OP !== 4'h1) begin
            n_err++;
            $display("FAIL basic_issue: got v=%b a=%h b=%h rd=%0d en=%b op=%h, want 1 0625 00cb 4 1 1",
                     OUT_VALID, OUT_A, OUT_B, OUT_RD, OUT_RD_EN, OUT_OP);
        end
        n_vec++;
        if (dut.u_sb.busy[4] !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy4: got %b, want 1", dut.u_sb.busy[4]);
        end
    endtask

    task automatic test_imm();
        present(4'h2, 3'd0, 3'd4, 3'd0, 1'b0);
        IN_USE_IMM = 1;
        IN_IMM     = 16'h1234;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL imm_no_stall: got ready=%b, want 1", IN_READY);
        end
        tick();
        idle();
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_B !== 16'h1234) begin
            n_err++;
            $display("FAIL imm_operand: got v=%b b=%h, want 1 1234", OUT_VALID, OUT_B);
        end
    endtask

    task automatic test_raw();
        do_reset();
        present(4'h3, 3'd0, 3'd1, 3'd4, 1'b1);
        tick();
        present(4'h4, 3'd4, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (IN_READY !== 1'b0) begin
                n_err++;
                $display("FAIL raw_stall: cycle %0d got ready=%b, want 0", i, IN_READY);
            end
            tick();
        end
        WB_WE = 1; WB_ADDR = 3'd4; WB_DATA = 16'hBEEF;
        #1;
`ifdef OPFETCH_FWD_EN
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL raw_fwd_ready: got %b, want 1", IN_READY);
        end
        tick();
`else
        n_vec++;
        if (IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL raw_nofwd_wbcycle: got %b, want 0", IN_READY);
        end
        tick();
        WB_WE = 0;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL raw_nofwd_ready: got %b, want 1", IN_READY);
        end
        tick();
`endif
        idle();
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 16'hBEEF || OUT_OP !== 4'h4) begin
            n_err++;
            $display("FAIL raw_operand: got v=%b a=%h op=%h, want 1 beef 4",
                     OUT_VALID, OUT_A, OUT_OP);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rf[1] = 16'h1111;
        rf[2] = 16'h2222;
        present(4'h3, 3'd1, 3'd2, 3'd6, 1'b0);
        OUT_READY = 0;
        tick();
        present(4'h5, 3'd2, 3'd1, 3'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (IN_READY !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready: cycle %0d got %b, want 0", i, IN_READY);
            end
            tick();
            n_vec++;
            if (OUT_VALID !== 1'b1 || OUT_A !== 16'h1111 || OUT_B !== 16'h2222
                || OUT_OP !== 4'h3 || OUT_RD !== 3'd6) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d got v=%b a=%h b=%h op=%h rd=%0d, want 1 1111 2222 3 6",
                         i, OUT_VALID, OUT_A, OUT_B, OUT_OP, OUT_RD);
            end
        end
        OUT_READY = 1;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got %b, want 1", IN_READY);
        end
        tick();
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 16'h2222 || OUT_OP !== 4'h5) begin
            n_err++;
            $display("FAIL bp_b2b_1: got v=%b a=%h op=%h, want 1 2222 5", OUT_VALID, OUT_A, OUT_OP);
        end
        present(4'h6, 3'd1, 3'd0, 3'd0, 1'b0);
        IN_USE_IMM = 1;
        IN_IMM     = 16'hABCD;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL bp_b2b_ready: got %b, want 1", IN_READY);
        end
        tick();
        idle();
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_B !== 16'hABCD || OUT_OP !== 4'h6) begin
            n_err++;
            $display("FAIL bp_b2b_2: got v=%b b=%h op=%h, want 1 abcd 6", OUT_VALID, OUT_B, OUT_OP);
        end
    endtask

    task automatic test_flush();
        do_reset();
        present(4'h7, 3'd0, 3'd1, 3'd5, 1'b1);
        OUT_READY = 0;
        tick();
        present(4'h8, 3'd2, 3'd3, 3'd0, 1'b0);
        FLUSH = 1;
        #1;
        n_vec++;
        if (IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_accept: got ready=%b, want 0", IN_READY);
        end
        tick();
        FLUSH = 0;
        n_vec++;
        if (OUT_VALID !== 1'b0 || dut.u_sb.busy[5] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: got v=%b busy5=%b, want 0 0",
                     OUT_VALID, dut.u_sb.busy[5]);
        end
        present(4'h9, 3'd5, 3'd5, 3'd0, 1'b0);
        OUT_READY = 1;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL flush_reader: got ready=%b, want 1", IN_READY);
        end
        tick();
        idle();
    endtask

    task automatic test_waw();
        do_reset();
        present(4'h1, 3'd0, 3'd1, 3'd4, 1'b1);
        tick();
        present(4'h9, 3'd0, 3'd1, 3'd4, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (IN_READY !== 1'b0) begin
                n_err++;
                $display("FAIL waw_stall: cycle %0d got %b, want 0", i, IN_READY);
            end
            tick();
        end
        WB_WE = 1; WB_ADDR = 3'd4; WB_DATA = 16'h5A5A;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL waw_release: got %b, want 1", IN_READY);
        end
        tick();
        idle();
        n_vec++;
        if (dut.u_sb.busy[4] !== 1'b1 || OUT_OP !== 4'h9 || OUT_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL waw_set_wins: got busy4=%b op=%h v=%b, want 1 9 1",
                     dut.u_sb.busy[4], OUT_OP, OUT_VALID);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        present(4'h2, 3'd0, 3'd1, 3'd3, 1'b1);
        OUT_READY = 0;
        tick();
        present(4'h3, 3'd3, 3'd0, 3'd0, 1'b0);
        #2;
        RST_N = 0;
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b0 || OUT_A !== '0 || OUT_RD_EN !== 1'b0
            || dut.u_sb.busy !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_clear: got v=%b a=%h en=%b busy=%h, want 0 0 0 00",
                     OUT_VALID, OUT_A, OUT_RD_EN, dut.u_sb.busy);
        end
        model_clear();
        idle();
        #3;
        RST_N = 1;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready: got %b, want 1", IN_READY);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            IN_VALID   = ($urandom_range(3) != 0);
            IN_OP      = OP_W'($urandom);
            IN_RS1     = ADDR_W'($urandom);
            IN_RS2     = ADDR_W'($urandom);
            IN_RD      = ADDR_W'($urandom);
            IN_RD_EN   = ($urandom_range(2) != 0);
            IN_USE_IMM = ($urandom_range(2) == 0);
            IN_IMM     = DATA_W'($urandom);
            OUT_READY  = ($urandom_range(3) != 0);
            FLUSH      = ($urandom_range(15) == 0);
            WB_WE      = ($urandom_range(2) == 0);
            WB_DATA    = DATA_W'($urandom);
            WB_ADDR    = ADDR_W'($urandom);
            for (int k = 0; k < 8 && m_busy != '0 && !m_busy[WB_ADDR]; k++)
                WB_ADDR = ADDR_W'($urandom);
            #1;
            n_vec++;
            if (IN_READY !== model_ready() || RADDR1 !== IN_RS1 || RADDR2 !== IN_RS2) begin
                n_err++;
                $display("FAIL rand_ready: cyc %0d got ready=%b r1=%0d r2=%0d, want %b %0d %0d",
                         cyc, IN_READY, RADDR1, RADDR2, model_ready(), IN_RS1, IN_RS2);
            end
            tick();
            n_vec++;
            if ({OUT_VALID, OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_RD_EN}
                !== {m_valid, m_op, m_a, m_b, m_rd, m_rd_en}
                || dut.u_sb.busy !== m_busy) begin
                n_err++;
                $display("FAIL rand_out: cyc %0d got v=%b op=%h a=%h b=%h rd=%0d en=%b busy=%h, want %b %h %h %h %0d %b %h",
                         cyc, OUT_VALID, OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_RD_EN,
                         dut.u_sb.busy, m_valid, m_op, m_a, m_b, m_rd, m_rd_en, m_busy);
            end
        end
        idle();
    endtask

    initial begin
        RST_N = 0;
        idle();
        model_clear();
        test_reset();
        test_basic();
        test_imm();
        test_raw();
        test_backpressure();
        test_flush();
        test_waw();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
